// File: rtl/servo_pwm_gen_pkg.sv
// Shared constants and helpers for the servo pulse generators.
// Kept free of per-instance parameters so later servo/timer blocks can import it.
package servo_pwm_gen_pkg;

    localparam int unsigned US_PER_S = 1000000;

    // Bits needed to hold position * span without losing anything before the >> 8.
    function automatic int unsigned prod_bits(input int unsigned span);
        return 8 + $clog2(span + 1);
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every DIV clocks.
// us_tick is combinational from the count so it lines up with the counter wrap.
module servo_tick_gen #(
    parameter int unsigned DIV = 50
) (
    input  logic clk,
    input  logic reset_n,
    output logic us_tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] prescaler;

    assign us_tick = (prescaler == PW'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (us_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo pulse generator: one pulse per frame, width set by an 8-bit position.
// Position and enable are sampled only at frame boundaries so pulses are never cut or stretched.
module servo_pwm_gen
    import servo_pwm_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned FRAME_US = 20000,
    parameter int unsigned MIN_US   = 1000,
    parameter int unsigned MAX_US   = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] position,
    input  logic       enable,
    output logic       pwm_out,
    output logic       frame_start,
    output logic [7:0] pos_latched
);

    localparam int unsigned US_DIV = CLK_HZ / US_PER_S;
    localparam int unsigned SPAN   = MAX_US - MIN_US;
    localparam int unsigned PROD_W = prod_bits(SPAN);
    // Widths are always below FRAME_US, so one counter width serves both sides of the compare.
    localparam int unsigned CNT_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    if ((CLK_HZ % US_PER_S) != 0 || US_DIV < 1) begin : g_bad_clk
        $error("servo_pwm_gen: CLK_HZ must be a nonzero multiple of 1 MHz");
    end
    if (MIN_US < 1) begin : g_bad_min
        $error("servo_pwm_gen: MIN_US must be at least 1");
    end
    if (!(MIN_US < MAX_US && MAX_US < FRAME_US)) begin : g_bad_range
        $error("servo_pwm_gen: need MIN_US < MAX_US < FRAME_US");
    end

    logic              us_tick;
    logic              frame_end;
    logic [CNT_W-1:0]  us_cnt;
    logic              en_latched;
    logic [CNT_W-1:0]  width_latched;
    logic [PROD_W-1:0] prod;
    logic [CNT_W-1:0]  width_next;

    servo_tick_gen #(
        .DIV(US_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .us_tick(us_tick)
    );

    assign frame_end  = us_tick && (us_cnt == CNT_W'(FRAME_US - 1));
    assign prod       = PROD_W'(position) * PROD_W'(SPAN);
    assign width_next = CNT_W'(MIN_US) + CNT_W'(prod >> 8);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            us_cnt <= '0;
        end else if (us_tick) begin
            us_cnt <= frame_end ? '0 : us_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_latched   <= '0;
            en_latched    <= 1'b0;
            width_latched <= CNT_W'(MIN_US);
        end else if (frame_end) begin
            pos_latched   <= position;
            en_latched    <= enable;
            width_latched <= width_next;
        end
    end

    // Registered compare: the pulse starts one clock after us_cnt returns to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pwm_out     <= en_latched && (us_cnt < width_latched);
            frame_start <= frame_end;
        end
    end

endmodule
